// File: rtl/k580vi53_host_pkg.sv
// Shared encodings for the K580VI53 host sequencer: command ops, rw field values,
// FSM states and the fixed control-word constants.
package k580vi53_host_pkg;

    typedef enum logic [1:0] {
        OP_MODE = 2'b00,
        OP_LOAD = 2'b01,
        OP_READ = 2'b10,
        OP_CFG  = 2'b11
    } op_e;

    localparam logic [1:0] RW_NONE = 2'b00;
    localparam logic [1:0] RW_LSB  = 2'b01;
    localparam logic [1:0] RW_MSB  = 2'b10;
    localparam logic [1:0] RW_BOTH = 2'b11;

    localparam logic [1:0] LATCH_CMD = 2'b00;
    localparam logic [1:0] CTRL_ADDR = 2'd3;
    localparam logic [2:0] MODE_MAX  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_DONE
    } state_e;

    // MODE and CFG carry a control word with their own rw field.
    function automatic logic is_mode_op(input op_e op);
        return (op == OP_MODE) || (op == OP_CFG);
    endfunction

endpackage

// File: rtl/k580vi53_host_seq.sv
// Access-list builder: describes access number idx_i (addr, data, direction, byte, last)
// for a command, given the effective rw.
module k580vi53_host_seq
    import k580vi53_host_pkg::*;
(
    input  op_e         op_i,
    input  logic [1:0]  ch_i,
    input  logic [1:0]  rw_i,
    input  logic [2:0]  mode_i,
    input  logic        bcd_i,
    input  logic [15:0] count_i,
    input  logic [1:0]  idx_i,
    output logic [1:0]  addr_o,
    output logic [7:0]  data_o,
    output logic        is_read_o,
    output logic        byte_hi_o,
    output logic        last_o
);

    logic       has_ctrl;
    logic [1:0] n_bytes;
    logic [2:0] total;
    logic [1:0] k;

    always_comb begin
        has_ctrl = (op_i != OP_LOAD);
        if (op_i == OP_MODE)
            n_bytes = 2'd0;
        else if ((rw_i == RW_LSB) || (rw_i == RW_MSB))
            n_bytes = 2'd1;
        else
            n_bytes = 2'd2;
        total     = {2'b00, has_ctrl} + {1'b0, n_bytes};
        last_o    = ({1'b0, idx_i} == (total - 3'd1));
        k         = idx_i - {1'b0, has_ctrl};
        byte_hi_o = (rw_i == RW_MSB) || ((rw_i == RW_BOTH) && k[0]);

        if (has_ctrl && (idx_i == 2'd0)) begin
            // READ opens with a counter-latch command, MODE/CFG with the control word.
            addr_o    = CTRL_ADDR;
            is_read_o = 1'b0;
            data_o    = (op_i == OP_READ) ? {ch_i, LATCH_CMD, 4'b0000}
                                          : {ch_i, rw_i, mode_i, bcd_i};
        end else begin
            addr_o    = ch_i;
            is_read_o = (op_i == OP_READ);
            data_o    = byte_hi_o ? count_i[15:8] : count_i[7:0];
        end
    end

endmodule

// File: rtl/k580vi53_host.sv
// Bus-initiator sequencer for a K580VI53 (8253) timer: expands MODE/LOAD/READ/CFG commands
// into timed byte accesses. Optional per-channel rw shadow: K580VI53_HOST_SHADOW_EN.
//   state    | meaning
//   S_IDLE   | ready, waiting for a command
//   S_SETUP  | addr/data driven, strobes idle
//   S_STROBE | pit_rd or pit_we_n active
//   S_HOLD   | strobe released, addr/data still held
//   S_DONE   | one-cycle response
module k580vi53_host
    import k580vi53_host_pkg::*;
#(
    parameter int unsigned STB_CYC   = 2,
    parameter int unsigned SETUP_CYC = 1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [1:0]  cmd_op_i,
    input  logic [1:0]  cmd_ch_i,
    input  logic [1:0]  cmd_rw_i,
    input  logic [2:0]  cmd_mode_i,
    input  logic        cmd_bcd_i,
    input  logic [15:0] cmd_count_i,
    output logic        rsp_valid_o,
    output logic        rsp_err_o,
    output logic [15:0] rsp_data_o,
    output logic [1:0]  pit_addr_o,
    output logic        pit_rd_o,
    output logic        pit_we_n_o,
    output logic [7:0]  pit_wdata_o,
    input  logic [7:0]  pit_rdata_i
);

    localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STB_LD   = 4'(STB_CYC - 1);

    state_e      state_q, state_d;
    op_e         op_q, op_d;
    logic [1:0]  ch_q, ch_d, rw_q, rw_d, idx_q, idx_d;
    logic [2:0]  mode_q, mode_d;
    logic        bcd_q, bcd_d, err_q, err_d, last_q, last_d;
    logic [15:0] count_q, count_d, rbuf_q, rbuf_d, rsp_data_q, rsp_data_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  pit_addr_q, pit_addr_d;
    logic [7:0]  pit_wdata_q, pit_wdata_d;
    logic        pit_rd_q, pit_rd_d, pit_we_n_q, pit_we_n_d;

    op_e         op_in;
    logic [1:0]  rw_in;
    logic        err_in, idle, accept;

    op_e         seq_op;
    logic [1:0]  seq_ch, seq_rw, seq_idx, seq_addr;
    logic [2:0]  seq_mode;
    logic        seq_bcd, seq_is_read, seq_byte_hi, seq_last;
    logic [15:0] seq_count;
    logic [7:0]  seq_data;

    assign op_in  = op_e'(cmd_op_i);
    assign idle   = (state_q == S_IDLE);
    assign accept = idle && cmd_valid_i;

`ifdef K580VI53_HOST_SHADOW_EN
    logic [1:0] shadow_q [3];
    logic [1:0] shadow_rw;

    always_comb begin
        case (cmd_ch_i)
            2'd0:    shadow_rw = shadow_q[0];
            2'd1:    shadow_rw = shadow_q[1];
            2'd2:    shadow_rw = shadow_q[2];
            default: shadow_rw = RW_BOTH;
        endcase
    end

    assign rw_in = is_mode_op(op_in) ? cmd_rw_i : shadow_rw;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < 3; i++) shadow_q[i] <= RW_BOTH;
        end else if (accept && is_mode_op(op_in) && !err_in) begin
            for (int i = 0; i < 3; i++)
                if (cmd_ch_i == 2'(i)) shadow_q[i] <= cmd_rw_i;
        end
    end
`else
    assign rw_in = cmd_rw_i;
`endif

    assign err_in = (cmd_ch_i == 2'd3) || (rw_in == RW_NONE)
                  || (is_mode_op(op_in) && (cmd_mode_i > MODE_MAX));

    // In IDLE the sequencer previews the incoming command so the first access is ready at accept.
    assign seq_op    = idle ? op_in       : op_q;
    assign seq_ch    = idle ? cmd_ch_i    : ch_q;
    assign seq_rw    = idle ? rw_in       : rw_q;
    assign seq_mode  = idle ? cmd_mode_i  : mode_q;
    assign seq_bcd   = idle ? cmd_bcd_i   : bcd_q;
    assign seq_count = idle ? cmd_count_i : count_q;
    assign seq_idx   = idle ? 2'd0 : ((state_q == S_HOLD) ? idx_q + 2'd1 : idx_q);

    k580vi53_host_seq u_seq (
        .op_i      (seq_op),
        .ch_i      (seq_ch),
        .rw_i      (seq_rw),
        .mode_i    (seq_mode),
        .bcd_i     (seq_bcd),
        .count_i   (seq_count),
        .idx_i     (seq_idx),
        .addr_o    (seq_addr),
        .data_o    (seq_data),
        .is_read_o (seq_is_read),
        .byte_hi_o (seq_byte_hi),
        .last_o    (seq_last)
    );

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        ch_d       = ch_q;
        rw_d       = rw_q;
        mode_d     = mode_q;
        bcd_d      = bcd_q;
        count_d    = count_q;
        err_d      = err_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        rbuf_d     = rbuf_q;
        rsp_data_d = rsp_data_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    op_d    = op_in;
                    ch_d    = cmd_ch_i;
                    rw_d    = rw_in;
                    mode_d  = cmd_mode_i;
                    bcd_d   = cmd_bcd_i;
                    count_d = cmd_count_i;
                    err_d   = err_in;
                    idx_d   = 2'd0;
                    cnt_d   = SETUP_LD;
                    rbuf_d  = 16'h0000;
                    state_d = err_in ? S_DONE : S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_STROBE;
                    cnt_d   = STB_LD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_STROBE: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_HOLD;
                    if (seq_is_read) begin
                        if (seq_byte_hi) rbuf_d[15:8] = pit_rdata_i;
                        else             rbuf_d[7:0]  = pit_rdata_i;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_HOLD: begin
                if (last_q) begin
                    state_d = S_DONE;
                    if (op_q == OP_READ) rsp_data_d = rbuf_q;
                end else begin
                    state_d = S_SETUP;
                    idx_d   = idx_q + 2'd1;
                    cnt_d   = SETUP_LD;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Bus outputs are registered from the next state so strobes are glitch-free.
    always_comb begin
        pit_addr_d  = pit_addr_q;
        pit_wdata_d = pit_wdata_q;
        last_d      = last_q;
        if ((state_d == S_SETUP) && (state_q != S_SETUP)) begin
            pit_addr_d  = seq_addr;
            pit_wdata_d = seq_data;
            last_d      = seq_last;
        end
        pit_rd_d   = (state_d == S_STROBE) && seq_is_read;
        pit_we_n_d = !((state_d == S_STROBE) && !seq_is_read);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            op_q        <= OP_MODE;
            ch_q        <= 2'd0;
            rw_q        <= RW_NONE;
            mode_q      <= 3'd0;
            bcd_q       <= 1'b0;
            count_q     <= 16'h0000;
            err_q       <= 1'b0;
            last_q      <= 1'b0;
            idx_q       <= 2'd0;
            cnt_q       <= 4'd0;
            rbuf_q      <= 16'h0000;
            rsp_data_q  <= 16'h0000;
            pit_addr_q  <= 2'd0;
            pit_wdata_q <= 8'h00;
            pit_rd_q    <= 1'b0;
            pit_we_n_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            ch_q        <= ch_d;
            rw_q        <= rw_d;
            mode_q      <= mode_d;
            bcd_q       <= bcd_d;
            count_q     <= count_d;
            err_q       <= err_d;
            last_q      <= last_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            rbuf_q      <= rbuf_d;
            rsp_data_q  <= rsp_data_d;
            pit_addr_q  <= pit_addr_d;
            pit_wdata_q <= pit_wdata_d;
            pit_rd_q    <= pit_rd_d;
            pit_we_n_q  <= pit_we_n_d;
        end
    end

    assign cmd_ready_o = idle;
    assign rsp_valid_o = (state_q == S_DONE);
    assign rsp_err_o   = (state_q == S_DONE) && err_q;
    assign rsp_data_o  = rsp_data_q;
    assign pit_addr_o  = pit_addr_q;
    assign pit_wdata_o = pit_wdata_q;
    assign pit_rd_o    = pit_rd_q;
    assign pit_we_n_o  = pit_we_n_q;

endmodule

// File: tb/tb_k580vi53_host.sv
// Bench for k580vi53_host: per-cycle timeline model of each command plus literal bus checks.
// Honours K580VI53_HOST_SHADOW_EN when defined.
module tb_k580vi53_host;

    localparam int SC  = 1;
    localparam int BC  = 2;
    localparam int LEN = SC + BC + 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op, cmd_ch, cmd_rw;
    logic [2:0]  cmd_mode;
    logic        cmd_bcd;
    logic [15:0] cmd_count;
    logic        rsp_valid, rsp_err;
    logic [15:0] rsp_data;
    logic [1:0]  pit_addr;
    logic        pit_rd, pit_we_n;
    logic [7:0]  pit_wdata, pit_rdata;

    int nchecks = 0;
    int nerrors = 0;

    // model state
    int          m_n;
    logic [1:0]  m_addr [4];
    logic [7:0]  m_data [4];
    bit          m_rd [4];
    bit          m_err;
    logic [15:0] m_old = 16'h0000;
    logic [15:0] m_new = 16'h0000;
    logic [1:0]  m_shadow [3];
    logic [15:0] m_lat = 16'h0000;
    logic [1:0]  m_rrw = 2'b11;
    bit          rd_flip = 1'b0;
    bit          run = 1'b0;
    int          t = 0;

    logic [9:0]  wq [$];
    int          rcnt = 0;
    logic        prev_we_n = 1'b1;
    logic        prev_rd = 1'b0;

    k580vi53_host #(.STB_CYC(BC), .SETUP_CYC(SC)) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_op_i    (cmd_op),
        .cmd_ch_i    (cmd_ch),
        .cmd_rw_i    (cmd_rw),
        .cmd_mode_i  (cmd_mode),
        .cmd_bcd_i   (cmd_bcd),
        .cmd_count_i (cmd_count),
        .rsp_valid_o (rsp_valid),
        .rsp_err_o   (rsp_err),
        .rsp_data_o  (rsp_data),
        .pit_addr_o  (pit_addr),
        .pit_rd_o    (pit_rd),
        .pit_we_n_o  (pit_we_n),
        .pit_wdata_o (pit_wdata),
        .pit_rdata_i (pit_rdata)
    );

    initial forever #5 clk = ~clk;

    // timer read-back model: latched value, byte order per effective rw
    always_comb begin
        case (m_rrw)
            2'b10:   pit_rdata = m_lat[15:8];
            2'b11:   pit_rdata = rd_flip ? m_lat[15:8] : m_lat[7:0];
            default: pit_rdata = m_lat[7:0];
        endcase
    end

    always @(negedge pit_rd) rd_flip = ~rd_flip;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s t=%0d at %0t: actual=%0h required=%0h", nm, t, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (prev_we_n && !pit_we_n) wq.push_back({pit_addr, pit_wdata});
        if (!prev_rd && pit_rd) rcnt++;
        prev_we_n = pit_we_n;
        prev_rd   = pit_rd;
    end

    // compare process: expected outputs for cycle t after accept
    always @(negedge clk) begin : cmp
        int  a, p;
        bit  strb;
        if (run) begin
            if (t < m_n * LEN) begin
                a    = t / LEN;
                p    = t % LEN;
                strb = (p >= SC) && (p < SC + BC);
                chk("pit_rd",    32'(pit_rd),    32'(m_rd[a] && strb));
                chk("pit_we_n",  32'(pit_we_n),  32'(!(!m_rd[a] && strb)));
                chk("pit_addr",  32'(pit_addr),  32'(m_addr[a]));
                if (!m_rd[a]) chk("pit_wdata", 32'(pit_wdata), 32'(m_data[a]));
                chk("busy_ready", 32'(cmd_ready), 32'd0);
                chk("busy_rsp_valid", 32'(rsp_valid), 32'd0);
                chk("busy_rsp_data", 32'(rsp_data), 32'(m_old));
            end else if (t == m_n * LEN) begin
                chk("done_rsp_valid", 32'(rsp_valid), 32'd1);
                chk("done_rsp_err",   32'(rsp_err),   32'(m_err));
                chk("done_ready",     32'(cmd_ready), 32'd0);
                chk("done_rsp_data",  32'(rsp_data),  32'(m_new));
                chk("done_strobes",   32'({pit_rd, pit_we_n}), 32'b01);
            end else begin
                chk("idle_ready",     32'(cmd_ready), 32'd1);
                chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
                chk("idle_rsp_data",  32'(rsp_data),  32'(m_new));
                chk("idle_strobes",   32'({pit_rd, pit_we_n}), 32'b01);
            end
            t++;
            if (t >= m_n * LEN + 2) run = 1'b0;
        end
    end

    task automatic push_acc(input logic [1:0] ad, input logic [7:0] d, input bit rd);
        m_addr[m_n] = ad;
        m_data[m_n] = d;
        m_rd[m_n]   = rd;
        m_n++;
    endtask

    task automatic send(input logic [1:0] op, input logic [1:0] ch, input logic [1:0] rw,
                        input logic [2:0] mode, input logic bcd, input logic [15:0] cnt,
                        input logic [15:0] lat, input bit hold);
        logic [1:0] rwe;
        bit         modeop;
        int         w;
        modeop = (op == 2'b00) || (op == 2'b11);
        rwe    = rw;
`ifdef K580VI53_HOST_SHADOW_EN
        if (!modeop) rwe = (ch == 2'd3) ? 2'b11 : m_shadow[ch];
`endif
        m_err = (ch == 2'd3) || (rwe == 2'b00) || (modeop && (mode > 3'd5));
        m_n   = 0;
        if (!m_err) begin
            if (op == 2'b10)      push_acc(2'd3, {ch, 6'b000000}, 1'b0);
            else if (op != 2'b01) push_acc(2'd3, {ch, rw, mode, bcd}, 1'b0);
            if (op != 2'b00) begin
                if (rwe[0]) push_acc(ch, cnt[7:0],  op == 2'b10);
                if (rwe[1]) push_acc(ch, cnt[15:8], op == 2'b10);
            end
        end
        m_new = m_old;
        if (op == 2'b10 && !m_err)
            m_new = {rwe[1] ? lat[15:8] : 8'h00, rwe[0] ? lat[7:0] : 8'h00};

        m_lat     = lat;
        m_rrw     = rwe;
        rd_flip   = 1'b0;
        wq.delete();
        rcnt      = 0;
        cmd_op    = op;
        cmd_ch    = ch;
        cmd_rw    = rw;
        cmd_mode  = mode;
        cmd_bcd   = bcd;
        cmd_count = cnt;
        cmd_valid = 1'b1;
        w = 0;
        while (!cmd_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!cmd_ready) begin
            nchecks++;
            nerrors++;
            $display("FAIL accept_timeout: actual=ready0 required=ready1");
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (!hold) cmd_valid = 1'b0;
        t   = 0;
        run = 1'b1;
        wait (run == 1'b0);
        m_old = m_new;
        if (modeop && !m_err) m_shadow[ch] = rw;
    endtask

    task automatic chk_writes(input string nm, input int n, input logic [9:0] e0,
                              input logic [9:0] e1, input logic [9:0] e2);
        chk({nm, "_nwrites"}, 32'(wq.size()), 32'(n));
        if (n > 0 && wq.size() > 0) chk({nm, "_w0"}, 32'(wq[0]), 32'(e0));
        if (n > 1 && wq.size() > 1) chk({nm, "_w1"}, 32'(wq[1]), 32'(e1));
        if (n > 2 && wq.size() > 2) chk({nm, "_w2"}, 32'(wq[2]), 32'(e2));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 3; i++) m_shadow[i] = 2'b11;
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_ch = 2'd0; cmd_rw = 2'b00;
        cmd_mode = 3'd0; cmd_bcd = 1'b0; cmd_count = 16'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_pit_addr", 32'(pit_addr), 32'd0);
        chk("rst_strobes", 32'({pit_rd, pit_we_n}), 32'b01);
        chk("rst_pit_wdata", 32'(pit_wdata), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        send(2'b00, 2'd1, 2'b11, 3'd3, 1'b0, 16'h0000, 16'h0000, 1'b0);
        chk_writes("mode_ch1", 1, {2'd3, 8'h76}, 10'h0, 10'h0);

        send(2'b11, 2'd0, 2'b11, 3'd2, 1'b0, 16'h1234, 16'h0000, 1'b0);
        chk_writes("cfg_ch0", 3, {2'd3, 8'h34}, {2'd0, 8'h34}, {2'd0, 8'h12});

        send(2'b10, 2'd2, 2'b11, 3'd0, 1'b0, 16'h0000, 16'hABCD, 1'b0);
        chk_writes("read_ch2", 1, {2'd3, 8'h80}, 10'h0, 10'h0);
        chk("read_ch2_nreads", 32'(rcnt), 32'd2);
        chk("read_ch2_data", 32'(rsp_data), 32'hABCD);

        send(2'b01, 2'd3, 2'b11, 3'd0, 1'b0, 16'h1111, 16'h0000, 1'b0);
        chk_writes("load_ch3", 0, 10'h0, 10'h0, 10'h0);
        chk("load_ch3_nreads", 32'(rcnt), 32'd0);

        send(2'b00, 2'd0, 2'b00, 3'd1, 1'b0, 16'h0000, 16'h0000, 1'b0);
        send(2'b00, 2'd2, 2'b11, 3'd6, 1'b0, 16'h0000, 16'h0000, 1'b0);
        chk_writes("mode6", 0, 10'h0, 10'h0, 10'h0);

        send(2'b00, 2'd1, 2'b01, 3'd0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        send(2'b10, 2'd1, 2'b01, 3'd0, 1'b0, 16'h0000, 16'h5A3C, 1'b0);
        chk("read_lsb_data", 32'(rsp_data), 32'h003C);
        send(2'b00, 2'd2, 2'b10, 3'd0, 1'b1, 16'h0000, 16'h0000, 1'b0);
        chk_writes("mode_ch2_bcd", 1, {2'd3, 8'hA1}, 10'h0, 10'h0);
        send(2'b10, 2'd2, 2'b10, 3'd0, 1'b0, 16'h0000, 16'h5A3C, 1'b0);
        chk("read_msb_data", 32'(rsp_data), 32'h5A00);

        send(2'b01, 2'd0, 2'b00, 3'd0, 1'b0, 16'h4321, 16'h0000, 1'b0);

        send(2'b01, 2'd2, 2'b10, 3'd0, 1'b0, 16'hBEEF, 16'h0000, 1'b1);
        chk_writes("b2b_first", 1, {2'd2, 8'hBE}, 10'h0, 10'h0);
        send(2'b01, 2'd1, 2'b01, 3'd0, 1'b0, 16'h0042, 16'h0000, 1'b0);
        chk_writes("b2b_second", 1, {2'd1, 8'h42}, 10'h0, 10'h0);

        // reset during the second byte strobe of a two-byte LOAD
        cmd_op = 2'b01; cmd_ch = 2'd0; cmd_rw = 2'b11; cmd_count = 16'h5678; cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("rstmid_in_strobe", 32'(pit_we_n), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("rstmid_we_n", 32'(pit_we_n), 32'd1);
        chk("rstmid_rd", 32'(pit_rd), 32'd0);
        chk("rstmid_ready", 32'(cmd_ready), 32'd1);
        chk("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) m_shadow[i] = 2'b11;
        m_old = 16'h0000;
        repeat (8) begin
            @(negedge clk);
            chk("rstmid_no_rsp", 32'(rsp_valid), 32'd0);
        end

        send(2'b00, 2'd0, 2'b01, 3'd0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        chk_writes("shadow_mode", 1, {2'd3, 8'h10}, 10'h0, 10'h0);
        send(2'b01, 2'd0, 2'b11, 3'd0, 1'b0, 16'h00FF, 16'h0000, 1'b0);
`ifdef K580VI53_HOST_SHADOW_EN
        chk_writes("shadow_load", 1, {2'd0, 8'hFF}, 10'h0, 10'h0);
`else
        chk_writes("shadow_load", 2, {2'd0, 8'hFF}, {2'd0, 8'h00}, 10'h0);
`endif

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
